// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU codes,
// sequencer states, IR field positions and opcode classification helpers.
package cpu_ctrl_pkg;

    localparam int IR_OPC_MSB = 31;
    localparam int IR_OPC_LSB = 27;
    localparam int IR_RA_MSB  = 26;
    localparam int IR_RA_LSB  = 23;
    localparam int IR_RB_MSB  = 22;
    localparam int IR_RB_LSB  = 19;
    localparam int IR_RC_MSB  = 18;
    localparam int IR_RC_LSB  = 15;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_SHR  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_OR   = 5'd10;
    localparam logic [4:0] OP_MUL  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_NEG  = 5'd16;
    localparam logic [4:0] OP_NOT  = 5'd17;
    localparam logic [4:0] OP_NOP  = 5'd24;
    localparam logic [4:0] OP_HALT = 5'd25;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_SHR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_ROR = 4'd6;
    localparam logic [3:0] ALU_ROL = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;
    localparam logic [3:0] ALU_NEG = 4'd10;
    localparam logic [3:0] ALU_NOT = 4'd11;

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALTED
    } state_t;

    function automatic logic isRegReg(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_OR);
    endfunction

    function automatic logic isMulDiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic isNegNot(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic [3:0] aluFromOpcode(input logic [4:0] op);
        logic [3:0] code;
        case (op)
            OP_AND:  code = ALU_AND;
            OP_OR:   code = ALU_OR;
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            OP_SHR:  code = ALU_SHR;
            OP_SHL:  code = ALU_SHL;
            OP_ROR:  code = ALU_ROR;
            OP_ROL:  code = ALU_ROL;
            OP_MUL:  code = ALU_MUL;
            OP_DIV:  code = ALU_DIV;
            OP_NEG:  code = ALU_NEG;
            OP_NOT:  code = ALU_NOT;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Turns a 4-bit register number into a one-hot register-file strobe,
// all zeros when not enabled.
module reg_sel_decoder (
    input  logic [3:0]  i_regNum,
    input  logic        i_en,
    output logic [15:0] o_oneHot
);

    always_comb begin
        o_oneHot = '0;
        if (i_en) begin
            o_oneHot[i_regNum] = 1'b1;
        end
    end

endmodule

// File: rtl/instr_control_unit.sv
// Hardwired T-state sequencer driving the datapath control strobes: fetch,
// decode and execute, with a sticky memory-wait timeout flag.
module instr_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int T_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [15:0] gpr_in,
    output logic [15:0] gpr_out,
    output logic        hi_in,
    output logic        lo_in,
    output logic        pc_in,
    output logic        pc_out,
    output logic        inc_pc,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        read,
    output logic        mdr_out,
    output logic        z_high_out,
    output logic        z_low_out,
    output logic [3:0]  alu_op,
    output logic        run,
    output logic        illegal,
    output logic        mem_timeout
);

    localparam int CNT_W = $clog2(T_WAIT_MAX + 2);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(T_WAIT_MAX);
    localparam bit TIMEOUT_EN = (T_WAIT_MAX != 0);

    state_t r_state;
    state_t w_nextState;
    logic [CNT_W-1:0] r_waitCnt;
    logic [CNT_W-1:0] w_waitNext;
    logic r_memTimeout;

    logic [4:0] w_opcode;
    logic [3:0] w_ra;
    logic [3:0] w_rb;
    logic [3:0] w_rc;
    logic w_isRegReg;
    logic w_isMulDiv;
    logic w_isNegNot;
    logic w_raEn;
    logic w_rbEn;
    logic w_rcEn;
    logic [15:0] w_raHot;
    logic [15:0] w_rbHot;
    logic [15:0] w_rcHot;
    logic w_unusedIrBits;

    assign w_opcode = ir[IR_OPC_MSB:IR_OPC_LSB];
    assign w_ra = ir[IR_RA_MSB:IR_RA_LSB];
    assign w_rb = ir[IR_RB_MSB:IR_RB_LSB];
    assign w_rc = ir[IR_RC_MSB:IR_RC_LSB];
    assign w_unusedIrBits = ^ir[IR_RC_LSB-1:0];

    assign w_isRegReg = isRegReg(w_opcode);
    assign w_isMulDiv = isMulDiv(w_opcode);
    assign w_isNegNot = isNegNot(w_opcode);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Counts consecutive T1 cycles spent waiting on memory; the flag only
    // reports the condition and never holds up the sequence.
    assign w_waitNext = r_waitCnt + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_waitCnt <= '0;
            r_memTimeout <= 1'b0;
        end else if (r_state == S_T1 && !mem_ready) begin
            if (r_waitCnt < WAIT_LIMIT) begin
                r_waitCnt <= w_waitNext;
            end
            if (TIMEOUT_EN && w_waitNext >= WAIT_LIMIT) begin
                r_memTimeout <= 1'b1;
            end
        end else begin
            r_waitCnt <= '0;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_RST: w_nextState = S_T0;
            S_T0:  w_nextState = S_T1;
            S_T1:  w_nextState = mem_ready ? S_T2 : S_T1;
            S_T2:  w_nextState = S_T3;
            S_T3: begin
                if (w_isRegReg || w_isMulDiv) begin
                    w_nextState = S_T4;
                end else if (w_isNegNot) begin
                    w_nextState = S_T5;
                end else if (w_opcode == OP_HALT) begin
                    w_nextState = S_HALTED;
                end else begin
                    w_nextState = S_T0;
                end
            end
            S_T4:     w_nextState = S_T5;
            S_T5:     w_nextState = w_isMulDiv ? S_T6 : S_T0;
            S_T6:     w_nextState = S_T0;
            S_HALTED: w_nextState = S_HALTED;
            default:  w_nextState = S_RST;
        endcase
    end

    // Moore strobe decode; only one bus driver is ever selected per state.
    always_comb begin
        hi_in = 1'b0;
        lo_in = 1'b0;
        pc_in = 1'b0;
        pc_out = 1'b0;
        inc_pc = 1'b0;
        ir_in = 1'b0;
        y_in = 1'b0;
        z_in = 1'b0;
        mar_in = 1'b0;
        mdr_in = 1'b0;
        read = 1'b0;
        mdr_out = 1'b0;
        z_high_out = 1'b0;
        z_low_out = 1'b0;
        alu_op = ALU_AND;
        illegal = 1'b0;
        w_raEn = 1'b0;
        w_rbEn = 1'b0;
        w_rcEn = 1'b0;
        case (r_state)
            S_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in = 1'b1;
                alu_op = ALU_ADD;
            end
            S_T1: begin
                z_low_out = 1'b1;
                pc_in = 1'b1;
                read = 1'b1;
                mdr_in = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in = 1'b1;
            end
            S_T3: begin
                if (w_isRegReg || w_isMulDiv) begin
                    w_rbEn = 1'b1;
                    y_in = 1'b1;
                end else if (w_isNegNot) begin
                    w_rbEn = 1'b1;
                    alu_op = aluFromOpcode(w_opcode);
                    z_in = 1'b1;
                end else if (w_opcode != OP_NOP && w_opcode != OP_HALT) begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin
                w_rcEn = 1'b1;
                alu_op = aluFromOpcode(w_opcode);
                z_in = 1'b1;
            end
            S_T5: begin
                z_low_out = 1'b1;
                if (w_isMulDiv) begin
                    lo_in = 1'b1;
                end else begin
                    w_raEn = 1'b1;
                end
            end
            S_T6: begin
                z_high_out = 1'b1;
                hi_in = 1'b1;
            end
            default: ;
        endcase
    end

    assign run = (r_state != S_RST) && (r_state != S_HALTED);
    assign mem_timeout = r_memTimeout;

    reg_sel_decoder u_raDec (
        .i_regNum (w_ra),
        .i_en     (w_raEn),
        .o_oneHot (w_raHot)
    );

    reg_sel_decoder u_rbDec (
        .i_regNum (w_rb),
        .i_en     (w_rbEn),
        .o_oneHot (w_rbHot)
    );

    reg_sel_decoder u_rcDec (
        .i_regNum (w_rc),
        .i_en     (w_rcEn),
        .o_oneHot (w_rcHot)
    );

    assign gpr_in = w_raHot;
    assign gpr_out = w_rbHot | w_rcHot;

endmodule

// File: tb/tb_instr_control_unit.sv
// Self-checking bench: an instruction-level model expands each instruction into
// its expected per-cycle strobes, compared against two DUTs with different timeouts.
module tb_instr_control_unit;

    localparam int WAIT_A = 15;
    localparam int WAIT_B = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic mem_ready = 1'b0;
    logic [31:0] ir = '0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] gin;
        logic [15:0] gout;
        logic hi;
        logic lo;
        logic pcIn;
        logic pcOut;
        logic incPc;
        logic irIn;
        logic yIn;
        logic zIn;
        logic marIn;
        logic mdrIn;
        logic rd;
        logic mdrOut;
        logic zh;
        logic zl;
        logic [3:0] alu;
        logic run;
        logic ill;
    } strobes_t;

    typedef struct {
        strobes_t s;
        logic mrdy;
        int waitIdx;
        logic loadIr;
        logic [31:0] instr;
        string tag;
    } cycle_t;

    cycle_t expQ[$];
    int checks = 0;
    int errors = 0;
    logic flagA = 1'b0;
    logic flagB = 1'b0;

    logic [15:0] gprInA, gprOutA, gprInB, gprOutB;
    logic hiInA, loInA, pcInA, pcOutA, incPcA, irInA, yInA, zInA, marInA, mdrInA, readA;
    logic mdrOutA, zHighOutA, zLowOutA, runA, illegalA, memTimeoutA;
    logic hiInB, loInB, pcInB, pcOutB, incPcB, irInB, yInB, zInB, marInB, mdrInB, readB;
    logic mdrOutB, zHighOutB, zLowOutB, runB, illegalB, memTimeoutB;
    logic [3:0] aluOpA, aluOpB;
    strobes_t actA, actB;

    assign actA = {gprInA, gprOutA, hiInA, loInA, pcInA, pcOutA, incPcA, irInA, yInA, zInA,
                   marInA, mdrInA, readA, mdrOutA, zHighOutA, zLowOutA, aluOpA, runA, illegalA};
    assign actB = {gprInB, gprOutB, hiInB, loInB, pcInB, pcOutB, incPcB, irInB, yInB, zInB,
                   marInB, mdrInB, readB, mdrOutB, zHighOutB, zLowOutB, aluOpB, runB, illegalB};

    instr_control_unit #(.T_WAIT_MAX(WAIT_A)) dutA (
        .clk(clk), .reset_n(reset_n), .ir(ir), .mem_ready(mem_ready),
        .gpr_in(gprInA), .gpr_out(gprOutA), .hi_in(hiInA), .lo_in(loInA),
        .pc_in(pcInA), .pc_out(pcOutA), .inc_pc(incPcA), .ir_in(irInA),
        .y_in(yInA), .z_in(zInA), .mar_in(marInA), .mdr_in(mdrInA), .read(readA),
        .mdr_out(mdrOutA), .z_high_out(zHighOutA), .z_low_out(zLowOutA),
        .alu_op(aluOpA), .run(runA), .illegal(illegalA), .mem_timeout(memTimeoutA)
    );

    instr_control_unit #(.T_WAIT_MAX(WAIT_B)) dutB (
        .clk(clk), .reset_n(reset_n), .ir(ir), .mem_ready(mem_ready),
        .gpr_in(gprInB), .gpr_out(gprOutB), .hi_in(hiInB), .lo_in(loInB),
        .pc_in(pcInB), .pc_out(pcOutB), .inc_pc(incPcB), .ir_in(irInB),
        .y_in(yInB), .z_in(zInB), .mar_in(marInB), .mdr_in(mdrInB), .read(readB),
        .mdr_out(mdrOutB), .z_high_out(zHighOutB), .z_low_out(zLowOutB),
        .alu_op(aluOpB), .run(runB), .illegal(illegalB), .mem_timeout(memTimeoutB)
    );

    function automatic logic [3:0] expAluOp(input logic [4:0] op);
        case (op)
            5'd9:    return 4'd0;
            5'd10:   return 4'd1;
            5'd3:    return 4'd2;
            5'd4:    return 4'd3;
            5'd5:    return 4'd4;
            5'd6:    return 4'd5;
            5'd7:    return 4'd6;
            5'd8:    return 4'd7;
            5'd14:   return 4'd8;
            5'd15:   return 4'd9;
            5'd16:   return 4'd10;
            5'd17:   return 4'd11;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [15:0] oneHot(input logic [3:0] r);
        return 16'd1 << r;
    endfunction

    task automatic pushCycle(input strobes_t s, input logic mrdy, input int waitIdx,
                             input logic loadIr, input logic [31:0] instr, input string tag);
        cycle_t c;
        c.s = s;
        c.mrdy = mrdy;
        c.waitIdx = waitIdx;
        c.loadIr = loadIr;
        c.instr = instr;
        c.tag = tag;
        expQ.push_back(c);
    endtask

    // Expands one instruction into the strobe pattern of every cycle it occupies.
    task automatic applyStimulus(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                                 input logic [3:0] rc, input int waits);
        logic [31:0] instr;
        strobes_t s;
        logic twoOperand;
        logic mulDiv;
        instr = {op, ra, rb, rc, 15'($urandom)};
        mulDiv = (op == 5'd14) || (op == 5'd15);
        twoOperand = (op >= 5'd3 && op <= 5'd10) || mulDiv;
        s = '0; s.run = 1; s.pcOut = 1; s.marIn = 1; s.incPc = 1; s.zIn = 1; s.alu = 4'd2;
        pushCycle(s, 1'($urandom), 0, 1'b0, '0, "T0");
        s = '0; s.run = 1; s.zl = 1; s.pcIn = 1; s.rd = 1; s.mdrIn = 1;
        for (int w = 1; w <= waits; w++) pushCycle(s, 1'b0, w, 1'b0, '0, "T1wait");
        pushCycle(s, 1'b1, 0, 1'b0, '0, "T1");
        s = '0; s.run = 1; s.mdrOut = 1; s.irIn = 1;
        pushCycle(s, 1'($urandom), 0, 1'b1, instr, "T2");
        if (twoOperand) begin
            s = '0; s.run = 1; s.gout = oneHot(rb); s.yIn = 1;
            pushCycle(s, 1'($urandom), 0, 1'b0, '0, "T3");
            s = '0; s.run = 1; s.gout = oneHot(rc); s.alu = expAluOp(op); s.zIn = 1;
            pushCycle(s, 1'($urandom), 0, 1'b0, '0, "T4");
            s = '0; s.run = 1; s.zl = 1;
            if (mulDiv) s.lo = 1; else s.gin = oneHot(ra);
            pushCycle(s, 1'($urandom), 0, 1'b0, '0, "T5");
            if (mulDiv) begin
                s = '0; s.run = 1; s.zh = 1; s.hi = 1;
                pushCycle(s, 1'($urandom), 0, 1'b0, '0, "T6");
            end
        end else if (op == 5'd16 || op == 5'd17) begin
            s = '0; s.run = 1; s.gout = oneHot(rb); s.alu = expAluOp(op); s.zIn = 1;
            pushCycle(s, 1'($urandom), 0, 1'b0, '0, "T3");
            s = '0; s.run = 1; s.zl = 1; s.gin = oneHot(ra);
            pushCycle(s, 1'($urandom), 0, 1'b0, '0, "T5");
        end else begin
            s = '0; s.run = 1;
            s.ill = (op != 5'd24) && (op != 5'd25);
            pushCycle(s, 1'($urandom), 0, 1'b0, '0, "T3");
            if (op == 5'd25) begin
                s = '0;
                for (int h = 0; h < 20; h++) pushCycle(s, 1'($urandom), 0, 1'b0, '0, "HALTED");
            end
        end
    endtask

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input strobes_t exp, input string tag);
        int drivers;
        checks++;
        if ({actA, memTimeoutA} !== {exp, flagA}) begin
            errors++;
            $display("[TB] FAIL dutA_%s: got %h, want %h", tag, {actA, memTimeoutA}, {exp, flagA});
        end
        checks++;
        if ({actB, memTimeoutB} !== {exp, flagB}) begin
            errors++;
            $display("[TB] FAIL dutB_%s: got %h, want %h", tag, {actB, memTimeoutB}, {exp, flagB});
        end
        drivers = $countones(gprOutA) + int'(pcOutA) + int'(mdrOutA) + int'(zHighOutA) + int'(zLowOutA);
        checks++;
        if (drivers > 1) begin
            errors++;
            $display("[TB] FAIL busDrivers_%s: got %0d drivers, want at most 1", tag, drivers);
        end
    endtask

    task automatic stepCycle(output string tag);
        cycle_t c;
        @(negedge clk);
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL modelQueue: got empty queue, want a pending cycle");
            tag = "";
        end else begin
            c = expQ.pop_front();
            mem_ready = c.mrdy;
            if (c.loadIr) ir = c.instr;
            #1;
            checkOutput(c.s, c.tag);
            if (WAIT_A != 0 && c.waitIdx >= WAIT_A) flagA = 1'b1;
            if (WAIT_B != 0 && c.waitIdx >= WAIT_B) flagB = 1'b1;
            tag = c.tag;
        end
    endtask

    task automatic drain();
        string t;
        while (expQ.size() > 0) stepCycle(t);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        strobes_t zero;
        string t;
        logic [4:0] opList[20] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd14, 5'd15,
                                   5'd16, 5'd17, 5'd24, 5'd0, 5'd11, 5'd12, 5'd13, 5'd18, 5'd30, 5'd31};
        zero = '0;

        repeat (2) begin
            @(negedge clk);
            #1 checkOutput(zero, "reset");
        end
        reset_n = 1'b1;
        mem_ready = 1'b1;
        #1 checkOutput(zero, "rstRelease");

        applyStimulus(5'd10, 4'd5, 4'd2, 4'd4, 0);
        checkValue("orLatency", 64'(expQ.size()), 64'd6);
        checkValue("orT3gout", 64'(expQ[3].s.gout), 64'h0004);
        checkValue("orT4alu", 64'({expQ[4].s.gout, expQ[4].s.alu, expQ[4].s.zIn}), 64'({16'h0010, 4'd1, 1'b1}));
        checkValue("orT5gin", 64'({expQ[5].s.gin, expQ[5].s.zl}), 64'({16'h0020, 1'b1}));
        drain();

        applyStimulus(5'd10, 4'd5, 4'd2, 4'd4, 3);
        drain();
        checkValue("timeoutA_3waits", 64'(memTimeoutA), 64'd0);
        checkValue("timeoutB_3waits", 64'(memTimeoutB), 64'd1);

        applyStimulus(5'd14, 4'd1, 4'd2, 4'd3, 0);
        checkValue("mulLatency", 64'(expQ.size()), 64'd7);
        checkValue("mulT5", 64'({expQ[5].s.lo, expQ[5].s.zl, expQ[5].s.gin}), 64'({1'b1, 1'b1, 16'h0000}));
        drain();

        applyStimulus(5'd17, 4'd6, 4'd7, 4'd0, 0);
        checkValue("notLatency", 64'(expQ.size()), 64'd5);
        checkValue("notT3", 64'({expQ[3].s.gout, expQ[3].s.alu}), 64'({16'h0080, 4'd11}));
        checkValue("notT5gin", 64'(expQ[4].s.gin), 64'h0040);
        drain();

        applyStimulus(5'd31, 4'd3, 4'd3, 4'd3, 0);
        checkValue("illLatency", 64'(expQ.size()), 64'd4);
        drain();

        for (int n = 0; n < 120; n++) begin
            applyStimulus(opList[$urandom_range(0, 19)], 4'($urandom), 4'($urandom), 4'($urandom),
                          int'($urandom_range(0, 3)));
            drain();
        end

        applyStimulus(5'd3, 4'd1, 4'd2, 4'd3, 14);
        drain();
        checkValue("timeoutA_14waits", 64'(memTimeoutA), 64'd0);
        applyStimulus(5'd3, 4'd1, 4'd2, 4'd3, 15);
        drain();
        checkValue("timeoutA_15waits", 64'(memTimeoutA), 64'd1);

        applyStimulus(5'd4, 4'd9, 4'd10, 4'd11, 1);
        for (int k = 0; k < 12; k++) begin
            stepCycle(t);
            if (t == "T4") break;
        end
        checkValue("reachedT4", 64'(t == "T4"), 64'd1);
        reset_n = 1'b0;
        flagA = 1'b0;
        flagB = 1'b0;
        expQ.delete();
        #1 checkOutput(zero, "asyncReset");
        @(negedge clk);
        #1 checkOutput(zero, "resetHeld");
        reset_n = 1'b1;
        mem_ready = 1'b1;
        #1 checkOutput(zero, "rstAfterAbort");

        applyStimulus(5'd9, 4'd0, 4'd15, 4'd8, 0);
        drain();
        applyStimulus(5'd16, 4'd12, 4'd0, 4'd0, 1);
        drain();

        applyStimulus(5'd25, 4'd0, 4'd0, 4'd0, 0);
        drain();
        checkValue("haltRun", 64'({runA, runB}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
